// File: rtl/rs_queue_pkg.sv
// Shared definitions for the multi-entry reservation station: widths, packet
// and entry layouts, and ROB-age helpers.
package rs_queue_pkg;

  localparam int ISSUE_WIDTH = 2;
  localparam int ROB_WIDTH   = 4;
  localparam int PRF_WIDTH   = 6;
  localparam int ROB_TAG_W   = ROB_WIDTH + 1;
  localparam int FU_ID_W     = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int OPCODE_W    = 4;

  typedef struct packed {
    logic                 packet_valid;
    logic [OPCODE_W-1:0]  opcode;
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [PRF_WIDTH-1:0] dest_prn;
    logic [PRF_WIDTH-1:0] op1_prn;
    logic [PRF_WIDTH-1:0] op2_prn;
    logic                 use_op1_prn;
    logic                 use_op2_prn;
    logic                 op1_ready;
    logic                 op2_ready;
    logic [FU_ID_W-1:0]   fu_id;
  } dispatch_rs_packet_t;

  typedef struct packed {
    logic                 packet_valid;
    logic [OPCODE_W-1:0]  opcode;
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [PRF_WIDTH-1:0] dest_prn;
    logic [PRF_WIDTH-1:0] op1_prn;
    logic [PRF_WIDTH-1:0] op2_prn;
    logic [FU_ID_W-1:0]   fu_id;
  } issue_packet_t;

  typedef struct packed {
    logic                 valid;
    logic                 op1_ready;
    logic                 op2_ready;
    logic                 use_op1_prn;
    logic                 use_op2_prn;
    logic [OPCODE_W-1:0]  opcode;
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [PRF_WIDTH-1:0] dest_prn;
    logic [PRF_WIDTH-1:0] op1_prn;
    logic [PRF_WIDTH-1:0] op2_prn;
    logic [FU_ID_W-1:0]   fu_id;
  } rs_entry_t;

  // Distance from the ROB head, wrap bit included; smaller means older.
  function automatic logic [ROB_TAG_W-1:0] rob_age(input logic [ROB_TAG_W-1:0] tag,
                                                   input logic [ROB_TAG_W-1:0] head);
    return tag - head;
  endfunction

  function automatic logic rob_younger(input logic [ROB_TAG_W-1:0] a,
                                       input logic [ROB_TAG_W-1:0] b,
                                       input logic [ROB_TAG_W-1:0] head);
    return rob_age(a, head) > rob_age(b, head);
  endfunction

  function automatic rs_entry_t make_entry(input dispatch_rs_packet_t pkt,
                                           input logic hit1, input logic hit2);
    rs_entry_t e;
    e.valid       = 1'b1;
    e.op1_ready   = pkt.op1_ready | (pkt.use_op1_prn & hit1);
    e.op2_ready   = pkt.op2_ready | (pkt.use_op2_prn & hit2);
    e.use_op1_prn = pkt.use_op1_prn;
    e.use_op2_prn = pkt.use_op2_prn;
    e.opcode      = pkt.opcode;
    e.rob_entry   = pkt.rob_entry;
    e.dest_prn    = pkt.dest_prn;
    e.op1_prn     = pkt.op1_prn;
    e.op2_prn     = pkt.op2_prn;
    e.fu_id       = pkt.fu_id;
    return e;
  endfunction

endpackage

// File: rtl/rs_queue_age_select.sv
// Oldest-request picker: a binary tree of age compares over a request vector,
// producing a one-hot grant and a valid flag.
module rs_age_select
  import rs_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AGE_W = ROB_TAG_W
) (
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);

  localparam int LEAVES = 1 << $clog2(DEPTH);
  localparam int NODES  = 2 * LEAVES - 1;
  localparam int IDX_W  = (LEAVES > 1) ? $clog2(LEAVES) : 1;

  logic             node_v   [NODES];
  logic [AGE_W-1:0] node_age [NODES];
  logic [IDX_W-1:0] node_idx [NODES];

  // Leaves sit at LEAVES-1..NODES-1; node n has children 2n+1 and 2n+2.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_v[n]   = 1'b0;
      node_age[n] = '0;
      node_idx[n] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      node_v[LEAVES-1+i]   = req[i];
      node_age[LEAVES-1+i] = age[i];
      node_idx[LEAVES-1+i] = IDX_W'(i);
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (node_v[2*n+2] && (!node_v[2*n+1] || (node_age[2*n+2] < node_age[2*n+1]))) begin
        node_v[n]   = 1'b1;
        node_age[n] = node_age[2*n+2];
        node_idx[n] = node_idx[2*n+2];
      end else begin
        node_v[n]   = node_v[2*n+1];
        node_age[n] = node_age[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (node_v[0]) grant[node_idx[0]] = 1'b1;
  end

  assign valid = node_v[0];

endmodule

// File: rtl/rs_queue.sv
// Multi-entry reservation station: dispatches up to DISP_WIDTH uops per cycle,
// wakes sources on writeback tags, issues the oldest ready uop per FU.
module rs_queue
  import rs_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DISP_WIDTH = 2,
  parameter int WB_PORTS   = ISSUE_WIDTH,
  parameter int NUM_FU     = ISSUE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pipe_flush,
  input  logic                                 squash_valid,
  input  logic [ROB_TAG_W-1:0]                 squash_rob,
  input  logic [ROB_TAG_W-1:0]                 rob_head,
  input  dispatch_rs_packet_t [DISP_WIDTH-1:0] dispatch_pkt,
  output logic                                 dispatch_ready,
  output logic [$clog2(DEPTH+1)-1:0]           free_count,
  input  logic [WB_PORTS-1:0]                  writeback_valid,
  input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0]   writeback_prn,
  input  logic [NUM_FU-1:0]                    fu_ready,
  output logic [NUM_FU-1:0]                    issue_valid,
  output issue_packet_t [NUM_FU-1:0]           issue_pkt
);

  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t ent_q   [DEPTH];
  rs_entry_t ent_nxt [DEPTH];

  logic [DEPTH-1:0]                valid_vec;
  logic [DEPTH-1:0]                ent_rdy;
  logic [DEPTH-1:0]                wake1;
  logic [DEPTH-1:0]                wake2;
  logic [DEPTH-1:0]                kill_vec;
  logic [DEPTH-1:0][ROB_TAG_W-1:0] age_vec;
  logic [DEPTH-1:0]                req   [NUM_FU];
  logic [DEPTH-1:0]                grant [NUM_FU];
  logic [NUM_FU-1:0]               cand;
  rs_entry_t                       pick_ent [NUM_FU];
  logic [DISP_WIDTH-1:0]           disp_hit1;
  logic [DISP_WIDTH-1:0]           disp_hit2;
  logic [DISP_WIDTH-1:0]           alloc_hit;
  logic [IDX_W-1:0]                alloc_idx [DISP_WIDTH];
  logic [DEPTH-1:0]                avail;
  logic [FC_W-1:0]                 free_cnt;

  // Per-entry status, ages and writeback tag matches.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ent_rdy[i]   = ent_q[i].valid
                   & (ent_q[i].op1_ready | ~ent_q[i].use_op1_prn)
                   & (ent_q[i].op2_ready | ~ent_q[i].use_op2_prn);
      age_vec[i]   = rob_age(ent_q[i].rob_entry, rob_head);
      kill_vec[i]  = ent_q[i].valid & rob_younger(ent_q[i].rob_entry, squash_rob, rob_head);
      wake1[i]     = 1'b0;
      wake2[i]     = 1'b0;
      for (int w = 0; w < WB_PORTS; w++) begin
        if (writeback_valid[w] && ent_q[i].use_op1_prn && (writeback_prn[w] == ent_q[i].op1_prn))
          wake1[i] = 1'b1;
        if (writeback_valid[w] && ent_q[i].use_op2_prn && (writeback_prn[w] == ent_q[i].op2_prn))
          wake2[i] = 1'b1;
      end
    end
    for (int s = 0; s < DISP_WIDTH; s++) begin
      disp_hit1[s] = 1'b0;
      disp_hit2[s] = 1'b0;
      for (int w = 0; w < WB_PORTS; w++) begin
        if (writeback_valid[w] && (writeback_prn[w] == dispatch_pkt[s].op1_prn)) disp_hit1[s] = 1'b1;
        if (writeback_valid[w] && (writeback_prn[w] == dispatch_pkt[s].op2_prn)) disp_hit2[s] = 1'b1;
      end
    end
  end

  // Free count comes from registered valid bits, so a same-cycle issue never
  // raises dispatch_ready.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!ent_q[i].valid) free_cnt = free_cnt + FC_W'(1);
  end

  assign free_count     = free_cnt;
  assign dispatch_ready = (free_cnt >= FC_W'(DISP_WIDTH));

  // Each valid slot takes the lowest-index free entry not claimed by an earlier slot.
  always_comb begin
    avail = ~valid_vec;
    for (int s = 0; s < DISP_WIDTH; s++) begin
      alloc_hit[s] = 1'b0;
      alloc_idx[s] = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (avail[i]) begin
          alloc_hit[s] = 1'b1;
          alloc_idx[s] = IDX_W'(i);
        end
      end
      if (alloc_hit[s] && dispatch_pkt[s].packet_valid) avail[alloc_idx[s]] = 1'b0;
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < DEPTH; i++)
        req[f][i] = ent_rdy[i] && (ent_q[i].fu_id == FU_ID_W'(f));
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    rs_age_select #(
      .DEPTH (DEPTH),
      .AGE_W (ROB_TAG_W)
    ) u_sel (
      .req   (req[f]),
      .age   (age_vec),
      .grant (grant[f]),
      .valid (cand[f])
    );
  end

  // Issue handshake: issue_valid[f] is already qualified by fu_ready[f]; when
  // high at a clock edge the uop is transferred and its entry freed on that edge.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      pick_ent[f] = '0;
      for (int i = 0; i < DEPTH; i++)
        if (grant[f][i]) pick_ent[f] = ent_q[i];
      issue_valid[f] = cand[f] & fu_ready[f] & ~pipe_flush
                     & ~(squash_valid & rob_younger(pick_ent[f].rob_entry, squash_rob, rob_head));
      issue_pkt[f]              = '0;
      issue_pkt[f].packet_valid = issue_valid[f];
      issue_pkt[f].opcode       = pick_ent[f].opcode;
      issue_pkt[f].rob_entry    = pick_ent[f].rob_entry;
      issue_pkt[f].dest_prn     = pick_ent[f].dest_prn;
      issue_pkt[f].op1_prn      = pick_ent[f].op1_prn;
      issue_pkt[f].op2_prn      = pick_ent[f].op2_prn;
      issue_pkt[f].fu_id        = pick_ent[f].fu_id;
    end
  end

  always_comb begin
    ent_nxt = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && wake1[i]) ent_nxt[i].op1_ready = 1'b1;
      if (ent_q[i].valid && wake2[i]) ent_nxt[i].op2_ready = 1'b1;
    end
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < DEPTH; i++)
        if (issue_valid[f] && grant[f][i]) ent_nxt[i] = '0;
    if (pipe_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_nxt[i] = '0;
    end else if (squash_valid) begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_vec[i]) ent_nxt[i] = '0;
    end else if (dispatch_ready) begin
      for (int s = 0; s < DISP_WIDTH; s++)
        if (dispatch_pkt[s].packet_valid && alloc_hit[s])
          ent_nxt[alloc_idx[s]] = make_entry(dispatch_pkt[s], disp_hit1[s], disp_hit2[s]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      ent_q <= ent_nxt;
    end
  end

endmodule

// File: tb/tb_rs_queue.sv
// Directed bench for rs_queue: issue order is checked against a scoreboard of
// expected {fu, rob} pairs; status outputs are checked at each step.
module tb_rs_queue;
  import rs_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int WB    = 2;
  localparam int NFU   = 2;

  logic                         clk;
  logic                         rst;
  logic                         pipe_flush;
  logic                         squash_valid;
  logic [ROB_TAG_W-1:0]         squash_rob;
  logic [ROB_TAG_W-1:0]         rob_head;
  dispatch_rs_packet_t [DW-1:0] dispatch_pkt;
  logic                         dispatch_ready;
  logic [3:0]                   free_count;
  logic [WB-1:0]                writeback_valid;
  logic [WB-1:0][PRF_WIDTH-1:0] writeback_prn;
  logic [NFU-1:0]               fu_ready;
  logic [NFU-1:0]               issue_valid;
  issue_packet_t [NFU-1:0]      issue_pkt;

  logic [6:0] exp_q[$];
  int checks;
  int errors;
  int t3_robs[3] = '{30, 2, 15};

  rs_queue #(.DEPTH(DEPTH), .DISP_WIDTH(DW), .WB_PORTS(WB), .NUM_FU(NFU)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_flush      (pipe_flush),
    .squash_valid    (squash_valid),
    .squash_rob      (squash_rob),
    .rob_head        (rob_head),
    .dispatch_pkt    (dispatch_pkt),
    .dispatch_ready  (dispatch_ready),
    .free_count      (free_count),
    .writeback_valid (writeback_valid),
    .writeback_prn   (writeback_prn),
    .fu_ready        (fu_ready),
    .issue_valid     (issue_valid),
    .issue_pkt       (issue_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dispatch_rs_packet_t mk(input int rob, input int fu, input int use1,
                                             input int prn1, input int rdy1);
    dispatch_rs_packet_t p;
    p              = '0;
    p.packet_valid = 1'b1;
    p.rob_entry    = ROB_TAG_W'(rob);
    p.dest_prn     = PRF_WIDTH'(rob);
    p.fu_id        = FU_ID_W'(fu);
    p.use_op1_prn  = use1[0];
    p.op1_prn      = PRF_WIDTH'(prn1);
    p.op1_ready    = rdy1[0];
    return p;
  endfunction

  task automatic push(input int fu, input int rob);
    exp_q.push_back({1'b1, fu[0], rob[4:0]});
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clr_in;
    dispatch_pkt    = '0;
    writeback_valid = '0;
    squash_valid    = 1'b0;
    pipe_flush      = 1'b0;
  endtask

  // Scoreboard: every accepted issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int f = 0; f < NFU; f++) begin
        if (issue_valid[f]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_issue: fu %0d rob %0d issued, expected none", f, issue_pkt[f].rob_entry);
          end else begin
            chk("issue_order", {issue_pkt[f].packet_valid, issue_pkt[f].fu_id, issue_pkt[f].rob_entry},
                exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clr_in;
    fu_ready      = '0;
    rob_head      = '0;
    squash_rob    = '0;
    writeback_prn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free", free_count, 8);
    chk("rst_dispatch_ready", dispatch_ready, 1);
    chk("rst_issue", issue_valid, 0);
    rst = 1'b0;

    // Two ready uops on different FUs.
    fu_ready = 2'b11;
    dispatch_pkt[0] = mk(1, 0, 0, 0, 1);
    dispatch_pkt[1] = mk(2, 1, 0, 0, 1);
    push(0, 1);
    push(1, 2);
    settle;
    chk("t1_no_same_cycle", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t1_free_after_disp", free_count, 6);
    chk("t1_issue", issue_valid, 2'b11);
    cyc; settle;
    chk("t1_free_after_issue", free_count, 8);

    // Wakeup by writeback: wrong tag first, then the matching tag on port 1.
    dispatch_pkt[0] = mk(3, 0, 1, 5, 0);
    cyc; clr_in;
    writeback_valid  = 2'b01;
    writeback_prn[0] = 6'd6;
    settle;
    chk("t2_wrong_tag", issue_valid, 0);
    cyc; clr_in;
    writeback_valid  = 2'b10;
    writeback_prn[1] = 6'd5;
    push(0, 3);
    settle;
    chk("t2_not_at_t", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t2_issue_t1", issue_valid, 2'b01);
    cyc;

    // Dispatch in the same cycle as the source writeback.
    dispatch_pkt[1]  = mk(4, 1, 1, 9, 0);
    writeback_valid  = 2'b01;
    writeback_prn[0] = 6'd9;
    push(1, 4);
    settle;
    chk("t2b_same_cycle", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t2b_issue", issue_valid, 2'b10);
    cyc; settle;
    chk("t2b_free", free_count, 8);

    // Age select with a wrapped ROB head.
    fu_ready = 2'b00;
    rob_head = 5'd14;
    dispatch_pkt[0] = mk(30, 0, 0, 0, 1);
    dispatch_pkt[1] = mk(2, 0, 0, 0, 1);
    cyc; clr_in;
    dispatch_pkt[0] = mk(15, 0, 0, 0, 1);
    cyc; clr_in; settle;
    chk("t3_held_free", free_count, 5);
    chk("t3_held_issue", issue_valid, 0);
    for (int a = 0; a < 32; a++)
      for (int k = 0; k < 3; k++)
        if (((t3_robs[k] - 14) & 31) == a) push(0, t3_robs[k]);
    fu_ready = 2'b01;
    settle;
    chk("t3_issue_a", issue_valid, 2'b01);
    cyc; settle;
    chk("t3_issue_b", issue_valid, 2'b01);
    cyc; settle;
    chk("t3_issue_c", issue_valid, 2'b01);
    cyc; settle;
    chk("t3_drained", issue_valid, 0);
    chk("t3_free", free_count, 8);

    // Full station, then squash younger than rob 10.
    fu_ready = 2'b00;
    rob_head = 5'd8;
    for (int k = 0; k < 4; k++) begin
      dispatch_pkt[0] = mk(8 + 2 * k, 0, 0, 0, 1);
      dispatch_pkt[1] = mk(9 + 2 * k, 0, 0, 0, 1);
      cyc; clr_in;
    end
    settle;
    chk("t4_full_free", free_count, 0);
    chk("t4_full_ready", dispatch_ready, 0);
    squash_valid = 1'b1;
    squash_rob   = 5'd10;
    push(0, 8);
    push(0, 9);
    push(0, 10);
    settle;
    chk("t4_squash_issue", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t4_after_squash_free", free_count, 5);
    fu_ready = 2'b01;
    settle;
    chk("t4_issue_a", issue_valid, 2'b01);
    cyc; settle;
    chk("t4_issue_b", issue_valid, 2'b01);
    cyc; settle;
    chk("t4_issue_c", issue_valid, 2'b01);
    cyc; settle;
    chk("t4_drained", issue_valid, 0);
    chk("t4_free", free_count, 8);

    // Squash masks a picked younger uop and drops same-cycle dispatch.
    fu_ready = 2'b00;
    dispatch_pkt[0] = mk(12, 1, 0, 0, 1);
    cyc; clr_in;
    fu_ready        = 2'b10;
    squash_valid    = 1'b1;
    squash_rob      = 5'd10;
    dispatch_pkt[0] = mk(13, 1, 0, 0, 1);
    settle;
    chk("t4_squash_mask", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t4_squash_drop_free", free_count, 8);
    chk("t4_squash_drop_issue", issue_valid, 0);

    // Fill, hold, release one entry.
    fu_ready = 2'b00;
    rob_head = 5'd0;
    for (int k = 0; k < 4; k++) begin
      dispatch_pkt[0] = mk(2 * k, 0, 0, 0, 1);
      dispatch_pkt[1] = mk(2 * k + 1, 0, 0, 0, 1);
      cyc; clr_in;
    end
    settle;
    chk("t5_full_free", free_count, 0);
    chk("t5_full_ready", dispatch_ready, 0);
    cyc; settle;
    chk("t5_hold_free", free_count, 0);
    fu_ready = 2'b01;
    push(0, 0);
    settle;
    chk("t5_issue", issue_valid, 2'b01);
    chk("t5_ready_during_issue", dispatch_ready, 0);
    cyc;
    fu_ready = 2'b00;
    settle;
    chk("t5_free_one", free_count, 1);
    chk("t5_ready_stays_low", dispatch_ready, 0);

    // Drain three, then flush with dispatch and writeback in the same cycle.
    fu_ready = 2'b01;
    push(0, 1);
    push(0, 2);
    push(0, 3);
    settle;
    chk("t6_drain_issue", issue_valid, 2'b01);
    cyc; cyc; cyc;
    fu_ready = 2'b00;
    settle;
    chk("t6_free_before_flush", free_count, 4);
    fu_ready         = 2'b11;
    pipe_flush       = 1'b1;
    dispatch_pkt[0]  = mk(20, 0, 0, 0, 1);
    dispatch_pkt[1]  = mk(21, 1, 0, 0, 1);
    writeback_valid  = 2'b11;
    writeback_prn[0] = 6'd1;
    writeback_prn[1] = 6'd2;
    settle;
    chk("t6_flush_issue", issue_valid, 0);
    cyc; clr_in; settle;
    chk("t6_flush_free", free_count, 8);
    chk("t6_flush_no_issue", issue_valid, 0);

    // Asynchronous reset between clock edges.
    fu_ready = 2'b00;
    dispatch_pkt[0] = mk(0, 0, 0, 0, 1);
    dispatch_pkt[1] = mk(1, 1, 0, 0, 1);
    cyc; clr_in; settle;
    chk("t6_pre_rst_free", free_count, 6);
    #1;
    rst      = 1'b1;
    fu_ready = 2'b11;
    #1;
    chk("t6_async_free", free_count, 8);
    chk("t6_async_ready", dispatch_ready, 1);
    chk("t6_async_issue", issue_valid, 0);
    #2;
    rst      = 1'b0;
    fu_ready = 2'b00;
    cyc; settle;
    chk("t6_post_rst_free", free_count, 8);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
